i2c_slave_responder: RTL
========================

// Module: i2c_slave_responder
// PURPOSE
//  Target-side (slave) I2C engine; the other end of the core-side master data path.
//  Detects START/STOP, shifts in the 7-bit address + R/W and ACKs on match.
//  Hands written bytes to the core and serializes read bytes onto SDA.
//  Open-drain lines: an output of 0 drives low; 1 releases.
// PARAMETERS
//  DATA_SIZE   8  width of one data byte (protocol fixes this at 8)
//  ADDR_SIZE   7  slave address width
//  SYNC_STAGES 2  synchronizer flops on SCL/SDA inputs (>=2)
// PORTS
//  i2c_core_clk_i  in   1          core clock; >=8x SCL rate, oversamples the bus
//  reset_i         in   1          synchronous, active-high reset
//  i2c_scl_i       in   1          SCL line
//  i2c_sda_i       in   1          SDA line
//  i2c_sda_o       out  1          SDA drive (0 = pull low, 1 = release)
//  i2c_scl_o       out  1          SCL drive for clock stretching (1 = release)
//  own_addr_i      in   ADDR_SIZE  this slave's address, sampled at address-byte end
//  rx_data_o       out  DATA_SIZE  byte received in a write transfer
//  rx_valid_o      out  1          1-cycle pulse: rx_data_o valid
//  rx_ready_i      in   1          core can accept a byte; 0 -> byte is NACKed
//  tx_data_i       in   DATA_SIZE  byte to return in a read transfer
//  tx_valid_i      in   1          tx_data_i valid
//  tx_ready_o      out  1          1-cycle pulse: tx_data_i captured
//  busy_o          out  1          1 from START until STOP
// BEHAVIOUR
//  Reset: state IDLE; i2c_sda_o=1, i2c_scl_o=1; rx_data_o=0; rx_valid_o, tx_ready_o, busy_o = 0.
//  SCL/SDA pass through SYNC_STAGES flops; edges come from the last stage vs its previous value.
//  START = SDA fall while SCL high; STOP = SDA rise while SCL high. Both are checked before any
//   state logic in the same cycle. START from any state -> ADDR (repeated start); STOP -> IDLE.
//  Data is sampled on SCL rise. i2c_sda_o changes only on the cycle after an SCL fall. MSB first.
//  A 3-bit bit counter loads 7 on entering ADDR, WRITE_DATA or READ_DATA and decrements per bit.
//  States: IDLE, ADDR, ADDR_ACK, WRITE_DATA, WRITE_ACK, READ_DATA, READ_ACK, WAIT_STOP.
//  ADDR: after the 8th bit, compare [7:1] with own_addr_i.
//   Match -> drive ACK (SDA=0) for one SCL period in ADDR_ACK.
//   Mismatch -> WAIT_STOP, SDA released.
//  ADDR_ACK -> WRITE_DATA if R/W=0, else READ_DATA. For a read, tx_data_i is captured on the SCL
//   fall that ends the ACK, with tx_ready_o pulsing that cycle.
//  WRITE_DATA: on the 8th bit, rx_data_o is updated and rx_valid_o pulses only if rx_ready_i=1.
//   Then WRITE_ACK: ACK if the byte was accepted, else NACK then WAIT_STOP.
//  READ_DATA: after 8 bits SDA is released; READ_ACK samples the master's bit on SCL rise.
//   ACK (0) -> capture the next byte and return to READ_DATA. NACK (1) -> WAIT_STOP.
//  tx_valid_i=0 at capture time: send 0xFF (no stretch build).
//  Reset mid-transfer: return to IDLE immediately and release both lines; the next START is needed.
// CONFIGURATION
//  I2C_SLAVE_CLK_STRETCH_EN defined:
//   At read-byte capture, if tx_valid_i=0, hold i2c_scl_o=0 until tx_valid_i=1.
//   Release SCL on the cycle after capture.
//  Not defined: i2c_scl_o is tied to 1 and a missing byte is sent as 0xFF.
// STRUCTURE
//  Shared package i2c_pkg: state encodings, I2C_ACK=1'b0, I2C_NACK=1'b1, DATA_SIZE/ADDR_SIZE defaults.
//  Sub-module i2c_line_sync: SYNC_STAGES synchronizer plus edge detect.
//   Outputs scl_rise, scl_fall, start_det and stop_det.
//  Top level holds the FSM, bit counter, shift register and ACK logic.
// TESTING
//  1. own_addr 0x50, master writes 0xA0 then 0x3C, rx_ready=1 -> ACKs on addr and data;
//     rx_data 0x3C with one rx_valid pulse.
//  2. Master sends addr 0x51 to own 0x50 -> no ACK (SDA stays 1); no rx_valid; busy until STOP.
//  3. Read 0xA1, tx_data 0x96 then 0x5A, master ACK then NACK -> bits 10010110, 01011010 on SDA;
//     two tx_ready pulses; then WAIT_STOP.
//  4. Write with rx_ready=0 on the 2nd byte -> 1st byte ACKed, 2nd NACKed; exactly one rx_valid.
//  5. Repeated START after the 4th data bit, then read of 0xA1 -> rejoins ADDR; partial byte dropped.
//  6. STRETCH_EN: read with tx_valid low for 50 cycles -> SCL held low 50+ cycles, then 0x96 sent;
//     without the macro 0xFF is sent.
//  7. Assert reset_i mid-byte -> both line outputs 1 next cycle; state IDLE.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target-side engine: FSM state encoding,
// ACK/NACK bit levels and default bus widths.
package i2c_pkg;

  localparam int unsigned DATA_SIZE_DEF = 8;
  localparam int unsigned ADDR_SIZE_DEF = 7;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WRITE_DATA,
    ST_WRITE_ACK,
    ST_READ_DATA,
    ST_READ_ACK,
    ST_WAIT_STOP
  } i2c_state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizer with edge detection; flags SCL edges and
// START (SDA fall while SCL high) / STOP (SDA rise while SCL high).
module i2c_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start_det,
  output logic o_stop_det
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_prev;
  logic                   r_sda_prev;
  logic                   w_scl;
  logic                   w_sda;

  // Not reset: forcing the chain high on reset could fake a START edge
  // if the bus happens to be low when reset is released.
  always_ff @(posedge i_clk) begin
    r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
    r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
    r_scl_prev <= w_scl;
    r_sda_prev <= w_sda;
  end

  assign w_scl = r_scl_sync[SYNC_STAGES-1];
  assign w_sda = r_sda_sync[SYNC_STAGES-1];

  assign o_sda       = w_sda;
  assign o_scl_rise  = ~r_scl_prev & w_scl;
  assign o_scl_fall  = r_scl_prev & ~w_scl;
  assign o_start_det = r_scl_prev & w_scl & r_sda_prev & ~w_sda;
  assign o_stop_det  = r_scl_prev & w_scl & ~r_sda_prev & w_sda;

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C target engine: address match/ACK, write bytes to the core, read bytes onto SDA.
// Define I2C_SLAVE_CLK_STRETCH_EN to stretch SCL while no read byte is available.
module i2c_slave_responder
  import i2c_pkg::*;
#(
  parameter int unsigned DATA_SIZE   = DATA_SIZE_DEF,
  parameter int unsigned ADDR_SIZE   = ADDR_SIZE_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 i2c_core_clk_i,
  input  logic                 reset_i,
  input  logic                 i2c_scl_i,
  input  logic                 i2c_sda_i,
  output logic                 i2c_sda_o,
  output logic                 i2c_scl_o,
  input  logic [ADDR_SIZE-1:0] own_addr_i,
  output logic [DATA_SIZE-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  input  logic [DATA_SIZE-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic                 busy_o
);

  localparam logic [2:0] CNT_LOAD = 3'd7;

  logic w_sda;
  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start_det;
  logic w_stop_det;

  i2c_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_line_sync (
    .i_clk       (i2c_core_clk_i),
    .i_scl       (i2c_scl_i),
    .i_sda       (i2c_sda_i),
    .o_sda       (w_sda),
    .o_scl_rise  (w_scl_rise),
    .o_scl_fall  (w_scl_fall),
    .o_start_det (w_start_det),
    .o_stop_det  (w_stop_det)
  );

  i2c_state_t           r_state, w_state_nxt;
  logic [2:0]           r_cnt, w_cnt_nxt;
  logic [DATA_SIZE-1:0] r_shift, w_shift_nxt;
  logic                 r_sda_o, w_sda_nxt;
  logic                 r_phase, w_phase_nxt;
  logic                 r_rw, w_rw_nxt;
  logic                 r_accept, w_accept_nxt;
  logic [DATA_SIZE-1:0] r_rx_data, w_rx_data_nxt;
  logic                 r_rx_valid, w_rx_valid_nxt;
  logic                 r_tx_ready, w_tx_ready_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 r_stretch, w_stretch_nxt;
  logic                 w_tx_req;
  logic                 w_tx_load;
  logic [DATA_SIZE-1:0] w_tx_byte;
  logic [DATA_SIZE-1:0] w_rx_byte;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
  logic                 r_scl_o, w_scl_nxt;
`endif

  assign w_rx_byte = {r_shift[DATA_SIZE-2:0], w_sda};

  always_ff @(posedge i2c_core_clk_i) begin
    if (reset_i) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_sda_o    <= 1'b1;
      r_phase    <= 1'b0;
      r_rw       <= 1'b0;
      r_accept   <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_tx_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_stretch  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_sda_o    <= w_sda_nxt;
      r_phase    <= w_phase_nxt;
      r_rw       <= w_rw_nxt;
      r_accept   <= w_accept_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_rx_valid <= w_rx_valid_nxt;
      r_tx_ready <= w_tx_ready_nxt;
      r_busy     <= w_busy_nxt;
      r_stretch  <= w_stretch_nxt;
    end
  end

`ifdef I2C_SLAVE_CLK_STRETCH_EN
  always_ff @(posedge i2c_core_clk_i) begin
    if (reset_i) r_scl_o <= 1'b1;
    else         r_scl_o <= w_scl_nxt;
  end
  assign i2c_scl_o = r_scl_o;
`else
  assign i2c_scl_o = 1'b1;
`endif

  // r_phase splits each ACK slot: 0 = before the ACK clock, 1 = ACK clock seen.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_shift_nxt    = r_shift;
    w_sda_nxt      = r_sda_o;
    w_phase_nxt    = r_phase;
    w_rw_nxt       = r_rw;
    w_accept_nxt   = r_accept;
    w_rx_data_nxt  = r_rx_data;
    w_rx_valid_nxt = 1'b0;
    w_tx_ready_nxt = 1'b0;
    w_busy_nxt     = r_busy;
    w_stretch_nxt  = r_stretch;
    w_tx_req       = 1'b0;
    w_tx_load      = 1'b0;
    w_tx_byte      = '1;
`ifdef I2C_SLAVE_CLK_STRETCH_EN
    w_scl_nxt      = 1'b1;
`endif

    if (w_stop_det) begin
      w_state_nxt   = ST_IDLE;
      w_sda_nxt     = 1'b1;
      w_busy_nxt    = 1'b0;
      w_stretch_nxt = 1'b0;
    end else if (w_start_det) begin
      w_state_nxt   = ST_ADDR;
      w_cnt_nxt     = CNT_LOAD;
      w_sda_nxt     = 1'b1;
      w_busy_nxt    = 1'b1;
      w_phase_nxt   = 1'b0;
      w_stretch_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_WAIT_STOP: ;

        ST_ADDR: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_rx_byte;
            w_cnt_nxt   = r_cnt - 3'd1;
            if (r_cnt == 3'd0) begin
              w_rw_nxt = w_sda;
              if (w_rx_byte[DATA_SIZE-1 -: ADDR_SIZE] == own_addr_i) begin
                w_state_nxt = ST_ADDR_ACK;
                w_phase_nxt = 1'b0;
              end else begin
                w_state_nxt = ST_WAIT_STOP;
              end
            end
          end
        end

        ST_ADDR_ACK: begin
          if (r_stretch) begin
            w_tx_req = 1'b1;
          end else if (w_scl_fall) begin
            if (!r_phase) begin
              w_sda_nxt   = I2C_ACK;
              w_phase_nxt = 1'b1;
            end else if (!r_rw) begin
              w_sda_nxt   = 1'b1;
              w_state_nxt = ST_WRITE_DATA;
              w_cnt_nxt   = CNT_LOAD;
            end else begin
              w_tx_req = 1'b1;
            end
          end
        end

        ST_WRITE_DATA: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_rx_byte;
            w_cnt_nxt   = r_cnt - 3'd1;
            if (r_cnt == 3'd0) begin
              w_state_nxt  = ST_WRITE_ACK;
              w_phase_nxt  = 1'b0;
              w_accept_nxt = rx_ready_i;
              if (rx_ready_i) begin
                w_rx_data_nxt  = w_rx_byte;
                w_rx_valid_nxt = 1'b1;
              end
            end
          end
        end

        ST_WRITE_ACK: begin
          if (w_scl_fall) begin
            if (!r_phase) begin
              w_sda_nxt   = r_accept ? I2C_ACK : I2C_NACK;
              w_phase_nxt = 1'b1;
            end else begin
              w_sda_nxt   = 1'b1;
              w_state_nxt = r_accept ? ST_WRITE_DATA : ST_WAIT_STOP;
              w_cnt_nxt   = CNT_LOAD;
            end
          end
        end

        ST_READ_DATA: begin
          if (w_scl_rise) begin
            w_cnt_nxt = r_cnt - 3'd1;
            if (r_cnt == 3'd0) begin
              w_state_nxt = ST_READ_ACK;
              w_phase_nxt = 1'b0;
            end
          end else if (w_scl_fall) begin
            w_sda_nxt   = r_shift[DATA_SIZE-1];
            w_shift_nxt = {r_shift[DATA_SIZE-2:0], 1'b1};
          end
        end

        ST_READ_ACK: begin
          if (r_stretch) begin
            w_tx_req = 1'b1;
          end else if (w_scl_fall) begin
            if (!r_phase) w_sda_nxt = 1'b1;
            else          w_tx_req  = 1'b1;
          end else if (w_scl_rise && !r_phase) begin
            if (w_sda == I2C_NACK) w_state_nxt = ST_WAIT_STOP;
            else                   w_phase_nxt = 1'b1;
          end
        end

        default: w_state_nxt = ST_IDLE;
      endcase
    end

    if (w_tx_req) begin
`ifdef I2C_SLAVE_CLK_STRETCH_EN
      if (tx_valid_i) begin
        w_tx_load = 1'b1;
      end else begin
        w_stretch_nxt = 1'b1;
        w_scl_nxt     = 1'b0;
      end
`else
      w_tx_load = 1'b1;
`endif
    end

    // The MSB goes straight onto SDA; the shifter keeps the remaining bits.
    if (w_tx_load) begin
      w_tx_byte      = tx_valid_i ? tx_data_i : '1;
      w_tx_ready_nxt = 1'b1;
      w_sda_nxt      = w_tx_byte[DATA_SIZE-1];
      w_shift_nxt    = {w_tx_byte[DATA_SIZE-2:0], 1'b1};
      w_state_nxt    = ST_READ_DATA;
      w_cnt_nxt      = CNT_LOAD;
      w_phase_nxt    = 1'b0;
      w_stretch_nxt  = 1'b0;
    end
  end

  assign i2c_sda_o  = r_sda_o;
  assign rx_data_o  = r_rx_data;
  assign rx_valid_o = r_rx_valid;
  assign tx_ready_o = r_tx_ready;
  assign busy_o     = r_busy;

endmodule
